// File: rtl/ocm_coeff_loader_pkg.sv
// Shared state encoding and default geometry for the OCM coefficient loader.
package ocm_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ISSUE_N,
    DRAIN_N,
    WAIT_N,
    ISSUE_C,
    DRAIN_C,
    WAIT_C,
    RUN,
    ERROR
  } loader_state_t;

  localparam int unsigned DEF_ADDR_WIDTH     = 14;
  localparam int unsigned DEF_LOC_WIDTH      = 8;
  localparam int unsigned DEF_ADDR_STEP      = 4;
  localparam int unsigned DEF_NOISE_BASE     = 'h000;
  localparam int unsigned DEF_NOISE_WORDS    = 128;
  localparam int unsigned DEF_CHAN_BASE      = 'h200;
  localparam int unsigned DEF_CHAN_WORDS     = 2;
  localparam int unsigned DEF_RD_LATENCY     = 1;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  function automatic logic is_busy_state(input loader_state_t s);
    return s inside {ISSUE_N, DRAIN_N, WAIT_N, ISSUE_C, DRAIN_C, WAIT_C};
  endfunction

endpackage

// File: rtl/ocm_coeff_loader_rd_align.sv
// Delay line that lines an issue-cycle {strobe, index} up with the memory read data.
// The index output only follows valid strobes, so it holds the last loaded location.
module ocm_rd_align #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 strobe,
  input  logic [IDX_WIDTH-1:0] index,
  output logic                 strobe_d,
  output logic [IDX_WIDTH-1:0] index_d
);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic [IDX_WIDTH-1:0] hold_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          hold_reg <= '0;
        end else if (strobe) begin
          hold_reg <= index;
        end
      end

      assign strobe_d = strobe;
      assign index_d  = strobe ? index : hold_reg;
    end else begin : g_pipe
      for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                 stb_in;
        logic [IDX_WIDTH-1:0] idx_in;
        logic                 stb_reg;
        logic [IDX_WIDTH-1:0] idx_reg;

        if (gi == 0) begin : g_head
          assign stb_in = strobe;
          assign idx_in = index;
        end else begin : g_link
          assign stb_in = g_stage[gi-1].stb_reg;
          assign idx_in = g_stage[gi-1].idx_reg;
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            stb_reg <= 1'b0;
            idx_reg <= '0;
          end else begin
            stb_reg <= stb_in;
            if (stb_in) begin
              idx_reg <= idx_in;
            end
          end
        end
      end

      assign strobe_d = g_stage[LATENCY-1].stb_reg;
      assign index_d  = g_stage[LATENCY-1].idx_reg;
    end
  endgenerate

endmodule

// File: rtl/ocm_coeff_loader.sv
// Sequencer loading the noise table then the channel/DFE tap table from OCM port 2.
// Optional WAIT watchdog with sticky error: define OCM_LOADER_TIMEOUT_EN.
module ocm_coeff_loader
  import ocm_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned LOC_WIDTH      = DEF_LOC_WIDTH,
  parameter int unsigned ADDR_STEP      = DEF_ADDR_STEP,
  parameter int unsigned NOISE_BASE     = DEF_NOISE_BASE,
  parameter int unsigned NOISE_WORDS    = DEF_NOISE_WORDS,
  parameter int unsigned CHAN_BASE      = DEF_CHAN_BASE,
  parameter int unsigned CHAN_WORDS     = DEF_CHAN_WORDS,
  parameter int unsigned RD_LATENCY     = DEF_RD_LATENCY,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  load_mem_n,
  output logic [LOC_WIDTH-1:0]  location_n,
  input  logic                  done_wait_n,
  output logic                  load_mem_c,
  output logic [LOC_WIDTH-1:0]  location_c,
  input  logic                  done_wait_c,
  output logic                  run_en,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned DRAIN_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] N_BASE = ADDR_WIDTH'(NOISE_BASE);
  localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(CHAN_BASE);
  localparam logic [LOC_WIDTH-1:0]  N_LAST = LOC_WIDTH'(NOISE_WORDS - 1);
  localparam logic [LOC_WIDTH-1:0]  C_LAST = LOC_WIDTH'(CHAN_WORDS - 1);
  localparam logic [LOC_WIDTH-1:0]  D_LAST = LOC_WIDTH'(DRAIN_LAST);
  localparam logic [LOC_WIDTH-1:0]  ONE    = LOC_WIDTH'(1);

  loader_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [LOC_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  start_q_reg;
  logic                  start_trig;

  assign start_trig = start & ~start_q_reg;

`ifdef OCM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt_reg;
  logic          in_wait;
  logic          timeout_hit;

  assign in_wait     = (state_reg == WAIT_N) || (state_reg == WAIT_C);
  assign timeout_hit = in_wait && (wait_cnt_reg == WAIT_LAST);

  // Cleared everywhere outside WAIT, so each WAIT visit starts counting from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_reg <= '0;
    end else if (in_wait) begin
      wait_cnt_reg <= wait_cnt_reg + TW'(1);
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign error = (state_reg == ERROR);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      mem_addr_reg <= N_BASE;
      cnt_reg      <= '0;
      start_q_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      cnt_reg      <= cnt_next;
      start_q_reg  <= start;
    end
  end

  // cnt_reg is the issue index in ISSUE_* and the drain counter in DRAIN_*.
  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    cnt_next      = cnt_reg;
    unique case (state_reg)
      IDLE, RUN: begin
        if (start_trig) begin
          mem_addr_next = N_BASE;
          cnt_next      = '0;
          state_next    = ISSUE_N;
        end
      end
      ISSUE_N: begin
        if (cnt_reg == N_LAST) begin
          cnt_next   = '0;
          state_next = DRAIN_N;
        end else begin
          cnt_next      = cnt_reg + ONE;
          mem_addr_next = mem_addr_reg + STEP;
        end
      end
      DRAIN_N: begin
        if (cnt_reg == D_LAST) begin
          cnt_next   = '0;
          state_next = WAIT_N;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      WAIT_N: begin
        if (done_wait_n) begin
          mem_addr_next = C_BASE;
          cnt_next      = '0;
          state_next    = ISSUE_C;
        end
`ifdef OCM_LOADER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ERROR;
        end
`endif
      end
      ISSUE_C: begin
        if (cnt_reg == C_LAST) begin
          cnt_next   = '0;
          state_next = DRAIN_C;
        end else begin
          cnt_next      = cnt_reg + ONE;
          mem_addr_next = mem_addr_reg + STEP;
        end
      end
      DRAIN_C: begin
        if (cnt_reg == D_LAST) begin
          cnt_next   = '0;
          state_next = WAIT_C;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      WAIT_C: begin
        if (done_wait_c) begin
          state_next = RUN;
        end
`ifdef OCM_LOADER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ERROR;
        end
`endif
      end
`ifdef OCM_LOADER_TIMEOUT_EN
      ERROR: begin
        if (start_trig) begin
          mem_addr_next = N_BASE;
          cnt_next      = '0;
          state_next    = ISSUE_N;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_addr = mem_addr_reg;
  assign busy     = is_busy_state(state_reg);
  // A reload edge in RUN removes the enable in the same cycle it is seen.
  assign run_en   = (state_reg == RUN) && !start_trig;

  ocm_rd_align #(
    .LATENCY   (RD_LATENCY),
    .IDX_WIDTH (LOC_WIDTH)
  ) u_align_n (
    .clk      (clk),
    .rstn     (rstn),
    .strobe   (state_reg == ISSUE_N),
    .index    (cnt_reg),
    .strobe_d (load_mem_n),
    .index_d  (location_n)
  );

  ocm_rd_align #(
    .LATENCY   (RD_LATENCY),
    .IDX_WIDTH (LOC_WIDTH)
  ) u_align_c (
    .clk      (clk),
    .rstn     (rstn),
    .strobe   (state_reg == ISSUE_C),
    .index    (cnt_reg),
    .strobe_d (load_mem_c),
    .index_d  (location_c)
  );

endmodule
